irq_ctrl: RTL and testbench

IRQ_CTRL -- requirements
Module: irq_ctrl

---
 rtl/irq_ctrl.sv | 202 ++++++++++++++++++++
 tb/tb_irq_ctrl.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/irq_ctrl.sv
// irq_ctrl: prioritised interrupt controller with per-source mask and
// edge/level selection, a three-state request/service handshake and a
// small word-addressed register file.
//
// Register words:
//   0 PEND   (RO)  pending sources
//   1 MASK   (RW)  1 = source enabled
//   2 EDGE   (RW)  1 = edge-triggered, 0 = level-triggered
//   3 CLR    (WO)  write-1-to-clear latched edge pendings
//   4 ACTIVE (RO)  {in_service, 27'b0, active_id}
//   5 EOI    (WO)  end of interrupt, data ignored
//   6-7            read as zero, writes ignored
//
// NSRC must lie in 1..16 so that a source index fits in active_id.
module irq_ctrl #(
  parameter int NSRC = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NSRC-1:0] src,
  output logic            irq,
  input  logic            irq_ack,
  input  logic [2:0]      bus_addr,
  input  logic [31:0]     bus_wdata,
  input  logic            bus_we,
  input  logic            bus_re,
  output logic [31:0]     bus_rdata,
  output logic [3:0]      active_id,
  output logic            in_service
);

  localparam logic [2:0] ADDR_PEND   = 3'd0;
  localparam logic [2:0] ADDR_MASK   = 3'd1;
  localparam logic [2:0] ADDR_EDGE   = 3'd2;
  localparam logic [2:0] ADDR_CLR    = 3'd3;
  localparam logic [2:0] ADDR_ACTIVE = 3'd4;
  localparam logic [2:0] ADDR_EOI    = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_SERVICE = 2'd2
  } state_t;

  // Registered state
  state_t          state_q, state_d;
  logic            irq_q, irq_d;
  logic [3:0]      active_id_q, active_id_d;
  logic            in_service_q, in_service_d;
  logic [31:0]     bus_rdata_q, bus_rdata_d;
  logic [NSRC-1:0] mask_q, mask_d;
  logic [NSRC-1:0] edge_q, edge_d;
  logic [NSRC-1:0] edge_pend_q, edge_pend_d;
  logic [NSRC-1:0] prev_q, prev_d;

  // Combinational helpers
  logic            wr_mask, wr_edge, wr_clr, wr_eoi;
  logic [NSRC-1:0] wdata_src;
  logic [NSRC-1:0] edge_set;
  logic [NSRC-1:0] clr_vec;
  logic [NSRC-1:0] edge_chg;
  logic [NSRC-1:0] acc_clr;
  logic [NSRC-1:0] pending;
  logic [NSRC-1:0] req_vec;
  logic [3:0]      win_idx;
  logic            win_found;
  logic            accept;

  // Only the low NSRC data bits address sources; the rest is deliberately dropped.
  logic            unused_bits;
  assign unused_bits = &{1'b0, bus_wdata};

  assign wdata_src = bus_wdata[NSRC-1:0];

  // Write strobes decoded per register word
  always_comb begin
    wr_mask = bus_we && (bus_addr == ADDR_MASK);
    wr_edge = bus_we && (bus_addr == ADDR_EDGE);
    wr_clr  = bus_we && (bus_addr == ADDR_CLR);
    wr_eoi  = bus_we && (bus_addr == ADDR_EOI);
  end

  // Edge detection only in edge mode, so a line held high across reset
  // release (EDGE cleared by reset) never produces a stale edge.
  assign edge_set = edge_q & src & ~prev_q;
  assign clr_vec  = wr_clr  ? wdata_src : '0;
  assign edge_chg = wr_edge ? (edge_q ^ wdata_src) : '0;

  // Per-source clear of the accepted winner
  for (genvar gi = 0; gi < NSRC; gi++) begin : g_acc_clr
    assign acc_clr[gi] = accept && (win_idx == 4'(gi));
  end

  // Edge bits report the latched pending, level bits follow the line directly
  assign pending = (edge_q & edge_pend_q) | (~edge_q & src);
  assign req_vec = pending & mask_q;

  // Lowest-index requester wins; index 0 is reported when nothing requests
  always_comb begin
    win_idx   = 4'd0;
    win_found = 1'b0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (req_vec[i]) begin
        win_idx   = 4'(i);
        win_found = 1'b1;
      end
    end
  end

  // Configuration registers and edge pending latch update
  always_comb begin
    mask_d = wr_mask ? wdata_src : mask_q;
    edge_d = wr_edge ? wdata_src : edge_q;
    prev_d = src;
    // A new edge beats CLR and acceptance; a mode change always wipes the bit.
    edge_pend_d = (edge_set | (edge_pend_q & ~(clr_vec | acc_clr))) & ~edge_chg;
  end

  // Request/service state machine: next state and outputs
  always_comb begin
    state_d      = state_q;
    active_id_d  = active_id_q;
    in_service_d = in_service_q;
    accept       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (|req_vec) begin
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        // Acknowledge takes priority over a collapsing request vector; with
        // no requester left the core still gets a (spurious) id 0 to EOI.
        if (irq_ack) begin
          state_d      = ST_SERVICE;
          active_id_d  = win_idx;
          in_service_d = 1'b1;
          accept       = win_found;
        end else if (!(|req_vec)) begin
          state_d = ST_IDLE;
        end
      end
      ST_SERVICE: begin
        if (wr_eoi) begin
          state_d      = ST_IDLE;
          in_service_d = 1'b0;
        end
      end
      default: begin
        state_d      = ST_IDLE;
        in_service_d = 1'b0;
      end
    endcase
    irq_d = (state_d == ST_REQ);
  end

  // Read data mux; sampled from current register values so a same-cycle
  // write to the same word is not visible yet
  always_comb begin
    bus_rdata_d = bus_rdata_q;
    if (bus_re) begin
      case (bus_addr)
        ADDR_PEND:   bus_rdata_d = 32'(pending);
        ADDR_MASK:   bus_rdata_d = 32'(mask_q);
        ADDR_EDGE:   bus_rdata_d = 32'(edge_q);
        ADDR_ACTIVE: bus_rdata_d = {in_service_q, 27'd0, active_id_q};
        default:     bus_rdata_d = 32'd0;
      endcase
    end
  end

  // State registers with asynchronous active-low clear
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      irq_q        <= 1'b0;
      active_id_q  <= 4'd0;
      in_service_q <= 1'b0;
      bus_rdata_q  <= 32'd0;
      mask_q       <= '0;
      edge_q       <= '0;
      edge_pend_q  <= '0;
      prev_q       <= '0;
    end else begin
      state_q      <= state_d;
      irq_q        <= irq_d;
      active_id_q  <= active_id_d;
      in_service_q <= in_service_d;
      bus_rdata_q  <= bus_rdata_d;
      mask_q       <= mask_d;
      edge_q       <= edge_d;
      edge_pend_q  <= edge_pend_d;
      prev_q       <= prev_d;
    end
  end

  assign irq        = irq_q;
  assign active_id  = active_id_q;
  assign in_service = in_service_q;
  assign bus_rdata  = bus_rdata_q;

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed testbench for irq_ctrl: linear sequence of steps with
// hand-computed expectations.
module tb_irq_ctrl;

  logic        clk;
  logic        rst;
  logic [15:0] src;
  logic        irq;
  logic        irq_ack;
  logic [2:0]  bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_we;
  logic        bus_re;
  logic [31:0] bus_rdata;
  logic [3:0]  active_id;
  logic        in_service;

  int checks = 0;
  int errors = 0;
  logic [31:0] rd;

  irq_ctrl #(.NSRC(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .src        (src),
    .irq        (irq),
    .irq_ack    (irq_ack),
    .bus_addr   (bus_addr),
    .bus_wdata  (bus_wdata),
    .bus_we     (bus_we),
    .bus_re     (bus_re),
    .bus_rdata  (bus_rdata),
    .active_id  (active_id),
    .in_service (in_service)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one cycle; inputs change and outputs are sampled 1ns after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
    bus_addr  = a;
    bus_wdata = d;
    bus_we    = 1'b1;
    tick();
    bus_we    = 1'b0;
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
    bus_addr = a;
    bus_re   = 1'b1;
    tick();
    bus_re   = 1'b0;
    d        = bus_rdata;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b0; src = '0; irq_ack = 1'b0;
    bus_addr = '0; bus_wdata = '0; bus_we = 1'b0; bus_re = 1'b0;
    tick(); tick();
    chk("reset_irq", 32'(irq), 32'd0);
    chk("reset_in_service", 32'(in_service), 32'd0);
    chk("reset_active_id", 32'(active_id), 32'd0);
    chk("reset_rdata", bus_rdata, 32'd0);
    rst = 1'b1;
    tick();

    // Register map basics
    bus_write(3'd1, 32'hFFFF_FFFF);
    bus_read(3'd1, rd);  chk("mask_upper_bits_zero", rd, 32'h0000_FFFF);
    bus_read(3'd2, rd);  chk("edge_reset_zero", rd, 32'h0000_0000);
    bus_read(3'd6, rd);  chk("addr6_reads_zero", rd, 32'h0000_0000);
    bus_write(3'd1, 32'h0000_0001);
    // Read and write of MASK in the same cycle returns the old value
    bus_addr = 3'd1; bus_wdata = 32'h0000_0003; bus_we = 1'b1; bus_re = 1'b1;
    tick();
    bus_we = 1'b0; bus_re = 1'b0;
    chk("rd_during_wr_old", bus_rdata, 32'h0000_0001);
    bus_read(3'd1, rd);  chk("rd_after_wr_new", rd, 32'h0000_0003);
    bus_write(3'd1, 32'h0000_0001);

    // Level source 0: request, acknowledge, EOI, re-request, withdraw
    src = 16'h0001;
    tick();
    chk("lvl_irq_up", 32'(irq), 32'd1);
    irq_ack = 1'b1; tick(); irq_ack = 1'b0;
    chk("lvl_irq_down_on_ack", 32'(irq), 32'd0);
    chk("lvl_in_service", 32'(in_service), 32'd1);
    bus_read(3'd4, rd);  chk("lvl_active_reg", rd, 32'h8000_0000);
    bus_write(3'd5, 32'd0);
    chk("lvl_eoi_in_service", 32'(in_service), 32'd0);
    chk("lvl_eoi_irq_low", 32'(irq), 32'd0);
    tick();
    chk("lvl_reassert", 32'(irq), 32'd1);
    src = 16'h0000;
    tick();
    chk("lvl_withdraw", 32'(irq), 32'd0);

    // Edge sources 5 and 3 rising together: 3 first, then 5
    bus_write(3'd2, 32'h0000_FFFF);
    bus_write(3'd1, 32'h0000_FFFF);
    src = 16'h0028;
    tick(); tick();
    chk("edge_irq_up", 32'(irq), 32'd1);
    irq_ack = 1'b1; tick(); irq_ack = 1'b0;
    chk("edge_first_id", 32'(active_id), 32'd3);
    bus_read(3'd0, rd);  chk("edge_pend_after_ack", rd, 32'h0000_0020);
    bus_write(3'd5, 32'd0);
    tick();
    chk("edge_irq_again", 32'(irq), 32'd1);
    irq_ack = 1'b1; tick(); irq_ack = 1'b0;
    chk("edge_second_id", 32'(active_id), 32'd5);
    bus_read(3'd0, rd);  chk("edge_pend_empty", rd, 32'h0000_0000);
    bus_write(3'd5, 32'd0);
    src = 16'h0000;
    tick();

    // Masked edge pending on bit 2; set beats a same-cycle CLR
    bus_write(3'd1, 32'h0000_FFFB);
    src = 16'h0004;
    tick(); tick(); tick();
    chk("masked_no_irq", 32'(irq), 32'd0);
    bus_read(3'd0, rd);  chk("masked_pend", rd, 32'h0000_0004);
    src = 16'h0000;
    tick();
    src = 16'h0004;
    bus_write(3'd3, 32'h0000_0004);
    bus_read(3'd0, rd);  chk("set_beats_clr", rd, 32'h0000_0004);
    bus_write(3'd3, 32'h0000_0004);
    bus_read(3'd0, rd);  chk("clr_clears", rd, 32'h0000_0000);
    chk("masked_still_no_irq", 32'(irq), 32'd0);

    // Level source 1: mask drop in REQ, idle ack, EOI outside service,
    // held acknowledge, spurious acceptance
    src = 16'h0000;
    bus_write(3'd1, 32'h0000_0002);
    bus_write(3'd2, 32'h0000_0000);
    src = 16'h0002;
    tick();
    chk("l1_irq_up", 32'(irq), 32'd1);
    bus_write(3'd1, 32'h0000_0000);
    chk("l1_irq_before_mask_effect", 32'(irq), 32'd1);
    tick();
    chk("l1_mask_drop_irq", 32'(irq), 32'd0);
    chk("l1_mask_drop_no_service", 32'(in_service), 32'd0);
    irq_ack = 1'b1; tick(); irq_ack = 1'b0;
    chk("idle_ack_ignored", 32'(in_service), 32'd0);
    bus_write(3'd1, 32'h0000_0002);
    tick();
    chk("l1_irq_up_again", 32'(irq), 32'd1);
    bus_write(3'd5, 32'd0);
    chk("eoi_in_req_ignored", 32'(irq), 32'd1);
    irq_ack = 1'b1; tick();
    chk("l1_accept_id", 32'(active_id), 32'd1);
    chk("l1_accept_irq_low", 32'(irq), 32'd0);
    tick(); tick();
    irq_ack = 1'b0;
    chk("held_ack_in_service", 32'(in_service), 32'd1);
    chk("held_ack_irq_low", 32'(irq), 32'd0);
    bus_write(3'd5, 32'd0);
    chk("l1_eoi", 32'(in_service), 32'd0);
    tick();
    chk("l1_reassert", 32'(irq), 32'd1);
    src = 16'h0000; irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
    chk("spurious_in_service", 32'(in_service), 32'd1);
    chk("spurious_id", 32'(active_id), 32'd0);
    bus_write(3'd5, 32'd0);
    tick();
    chk("spurious_done_irq", 32'(irq), 32'd0);

    // Reset in SERVICE with edge source 1 held high
    bus_write(3'd2, 32'h0000_FFFF);
    bus_write(3'd1, 32'h0000_FFFF);
    src = 16'h0002;
    tick(); tick();
    chk("r_irq_up", 32'(irq), 32'd1);
    bus_read(3'd0, rd);  chk("r_pend", rd, 32'h0000_0002);
    irq_ack = 1'b1; tick(); irq_ack = 1'b0;
    chk("r_in_service", 32'(in_service), 32'd1);
    rst = 1'b0;
    #1;
    chk("r_async_irq", 32'(irq), 32'd0);
    chk("r_async_in_service", 32'(in_service), 32'd0);
    chk("r_async_active_id", 32'(active_id), 32'd0);
    chk("r_async_rdata", bus_rdata, 32'd0);
    tick(); tick();
    rst = 1'b1;
    bus_write(3'd2, 32'h0000_FFFF);
    bus_write(3'd1, 32'h0000_FFFF);
    tick(); tick(); tick();
    chk("r_no_residual_irq", 32'(irq), 32'd0);
    bus_read(3'd0, rd);  chk("r_no_edge_held_high", rd, 32'h0000_0000);
    src = 16'h0000;
    tick();
    src = 16'h0002;
    tick(); tick();
    chk("r_new_edge_irq", 32'(irq), 32'd1);
    irq_ack = 1'b1; tick(); irq_ack = 1'b0;
    chk("r_new_edge_id", 32'(active_id), 32'd1);
    chk("r_new_edge_in_service", 32'(in_service), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
